// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier, WIDTH cycles per product; SIGNED_MODE_EN adds tc for two's-complement operands
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MODE_EN
  input  logic               tc,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand, r_mplier;
  logic [WIDTH:0]     r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_busy, r_done;
  logic [2*WIDTH-1:0] r_product;
  logic               w_accept;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod, w_result;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
`ifdef SIGNED_MODE_EN
  logic               r_sign, w_sign;
  assign w_a_mag  = (tc && a[WIDTH-1]) ? -a : a;
  assign w_b_mag  = (tc && b[WIDTH-1]) ? -b : b;
  assign w_sign   = tc & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_result = r_sign ? -w_prod : w_prod;
`else
  assign w_a_mag  = a;
  assign w_b_mag  = b;
  assign w_result = w_prod;
`endif
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_sum    = r_acc + (WIDTH+1)'(r_mplier[0] ? r_mcand : '0);
  // {acc, mplier} after this step's right shift, acc's top bit being zero
  assign w_prod   = {w_sum, r_mplier[WIDTH-1:1]};
  assign busy     = r_busy;
  assign done     = r_done;
  assign product  = r_product;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
`ifdef SIGNED_MODE_EN
      r_sign    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state  <= RUN;
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
`ifdef SIGNED_MODE_EN
      r_sign   <= w_sign;
`endif
    end else if (r_state == RUN) begin
      r_acc    <= {1'b0, w_sum[WIDTH:1]};
      r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == CW'(WIDTH-1)) begin
        r_product <= w_result;
        r_state   <= DONE;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
      end
    end else begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of seq_multiplier at WIDTH=8 and WIDTH=3
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst;
  logic s8, busy8, done8;
  logic [7:0] a8, b8;
  logic [15:0] product8;
  logic s3, busy3, done3;
  logic [2:0] a3, b3;
  logic [5:0] product3;
  int checks = 0;
  int errors = 0;
`ifdef SIGNED_MODE_EN
  logic tc8;
`endif

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
`ifdef SIGNED_MODE_EN
    .tc(tc8),
`endif
    .busy(busy8), .done(done8), .product(product8)
  );

  seq_multiplier #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3),
`ifdef SIGNED_MODE_EN
    .tc(1'b0),
`endif
    .busy(busy3), .done(done3), .product(product3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] exp, input string tag);
    int k, bc;
    @(negedge clk); a8 = ta; b8 = tb_v; s8 = 1'b1;
    @(posedge clk);
    @(negedge clk); s8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
    k = 0; bc = 0;
    while (!done8 && k < 30) begin
      if (busy8) bc++;
      @(negedge clk); k++;
    end
    chk({tag, " latency"}, k, 8);
    chk({tag, " busy_cycles"}, bc, 8);
    chk({tag, " product"}, product8, exp);
    chk({tag, " busy_at_done"}, busy8, 0);
    @(negedge clk);
    chk({tag, " done_drop"}, done8, 0);
    chk({tag, " product_hold"}, product8, exp);
  endtask

  task automatic op3(input logic [2:0] ta, input logic [2:0] tb_v, input logic [5:0] exp);
    int k;
    @(negedge clk); a3 = ta; b3 = tb_v; s3 = 1'b1;
    @(posedge clk);
    @(negedge clk); s3 = 1'b0;
    k = 0;
    while (!done3 && k < 20) begin
      @(negedge clk); k++;
    end
    chk($sformatf("w3 %0d*%0d latency", ta, tb_v), k, 3);
    chk($sformatf("w3 %0d*%0d product", ta, tb_v), product3, exp);
  endtask

  initial begin
    int k, n;
    logic [2:0] x, y;
    rst = 1'b1; s8 = 1'b0; s3 = 1'b0; a8 = '0; b8 = '0; a3 = '0; b3 = '0;
`ifdef SIGNED_MODE_EN
    tc8 = 1'b0;
`endif
    @(negedge clk);
    chk("reset busy", busy8, 0);
    chk("reset done", done8, 0);
    chk("reset product", product8, 0);
    chk("reset product3", product3, 0);
    rst = 1'b0;

    op8(8'd13, 8'd11, 16'd143, "13x11");
    op8(8'd255, 8'd255, 16'hFE01, "255x255");
    op8(8'd0, 8'd200, 16'd0, "0x200");

    // back-to-back with start held high throughout
    @(negedge clk); a8 = 8'd3; b8 = 8'd4; s8 = 1'b1;
    @(posedge clk);
    @(negedge clk); a8 = 8'd9; b8 = 8'd9;
    k = 0;
    while (!done8 && k < 30) begin
      @(negedge clk); k++;
    end
    chk("b2b first latency", k, 8);
    chk("b2b first product", product8, 12);
    a8 = 8'd5; b8 = 8'd6;
    @(posedge clk);
    @(negedge clk); a8 = 8'd7; b8 = 8'd7;
    k = 1;
    while (!done8 && k < 30) begin
      @(negedge clk); k++;
    end
    s8 = 1'b0;
    chk("b2b gap", k, 9);
    chk("b2b second product", product8, 30);

    // reset mid-run
    @(negedge clk); a8 = 8'd100; b8 = 8'd100; s8 = 1'b1;
    @(posedge clk);
    @(negedge clk); s8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst busy_before", busy8, 1);
    rst = 1'b1;
    #1;
    chk("midrst busy", busy8, 0);
    chk("midrst done", done8, 0);
    chk("midrst product", product8, 0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) n++;
    end
    chk("midrst no_done", n, 0);
    op8(8'd2, 8'd3, 16'd6, "2x3");

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        x = 3'(i); y = 3'(j);
        op3(x, y, 6'(i * j));
      end

`ifdef SIGNED_MODE_EN
    tc8 = 1'b1;
    op8(8'hFD, 8'd5, 16'hFFF1, "s -3x5");
    op8(8'h80, 8'h80, 16'h4000, "s -128x-128");
    op8(8'h7F, 8'h80, 16'hC080, "s 127x-128");
    tc8 = 1'b0;
    op8(8'hFD, 8'd5, 16'd1265, "u 253x5");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised, sequential shift-and-add unsigned multiplier and the successor to the fixed 3-bit combinational array multiplier. It accepts two WIDTH-bit operands through a start/busy/done handshake and retires one partial product per clock. It produces a full 2*WIDTH-bit product after WIDTH compute cycles. It is the area-cheap multiplier for datapaths where latency is acceptable.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high; clears all state.
start  input  1  request; sampled only in IDLE or DONE.
a  input  WIDTH  multiplicand; captured on the accepting edge.
b  input  WIDTH  multiplier; captured on the accepting edge.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; product is valid.
product  output  2*WIDTH  result register; holds its value until the next accepted start or reset.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0, internal accumulator, operand registers and counter all 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge accepts the operation.
  - Latches a into mcand and b into mplier; clears acc (WIDTH+1 bits); step counter=0; goes to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - If mplier[0]=1, then {acc} = acc + mcand; the carry is kept in the extra bit.
  - Shift {acc, mplier} right by one.
  - counter increments.
  - When counter reaches WIDTH-1 at the edge, the step completes, product <= the final {acc[WIDTH-1:0], mplier}, and the state goes to DONE.
- RUN is always exactly WIDTH cycles. There is no early termination, including for zero operands.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted, identical to IDLE (back-to-back operation; next product after another WIDTH+1 cycles).
  - Otherwise the state goes to IDLE.
- Latency: start accepted at edge E0 gives busy=1 after E0 through edge E0+WIDTH. done=1 and product valid after edge E0+WIDTH, during one cycle. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. a and b may change freely during RUN with no effect.
- busy and done are never high together.
- Width rule: product is exact modulo nothing. The maximum is (2^WIDTH-1)^2, which is less than 2^(2*WIDTH). There is no overflow flag.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. The partial result is discarded, and no done pulse follows.

Optional Feature:
SIGNED_MODE_EN
- Defined:
  - Adds input port tc (1 bit), captured on the accepting edge.
  - tc=1 treats a and b as two's complement. The unit latches the magnitudes |a| and |b| (WIDTH-bit unsigned) and records sign = a[MSB]^b[MSB]. It runs the same unsigned RUN sequence, then two's-complement-negates the 2*WIDTH result on the transition into DONE when sign=1.
  - Latency is unchanged.
  - -2^(WIDTH-1) operands are handled exactly, e.g. 8-bit -128*-128 = 16384.
  - tc=0 behaves exactly as unsigned.
- Undefined: no tc port; unsigned only.

Test Plan:
1. WIDTH=8: a=13, b=11, start for 1 cycle -> busy for 8 cycles, done pulse 8 cycles after the accepting edge, product=143; product holds 143 after done drops.
2. WIDTH=8: a=255, b=255 -> product=65025 (0xFE01). Then a=0, b=200 -> product=0, still 8 busy cycles.
3. WIDTH=8: start held high continuously with a=3,b=4 then a=5,b=6 presented in DONE -> 12 then 30. Second done follows the first by exactly 9 cycles. start/a/b changes during RUN are ignored.
4. WIDTH=8: start a=100,b=100, assert rst after 4 RUN cycles -> busy, done and product go 0 immediately. No done pulse. A subsequent start a=2,b=3 -> product=6.
5. WIDTH=3: exhaustive 64 operand pairs, compared against a*b. Includes 7*7=49 in 3 cycles, matching the legacy 3-bit multiplier results.
6. SIGNED_MODE_EN, WIDTH=8, tc=1:
   - -3*5 -> 0xFFF1.
   - -128*-128 -> 0x4000.
   - 127*-128 -> 0xC080.
   - With tc=0, 0xFD*5 -> 1265.
